// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: result word and register-file address widths.
package cpu_pkg;

  localparam int unsigned WORD_WIDTH     = 16;
  localparam int unsigned REG_ADDR_WIDTH = 4;

  typedef logic [WORD_WIDTH-1:0]     word_t;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Bundle of source-side valid/ready requests and the register-file write-port slot.
// The master modport is the environment (sources + register file); slave is the arbiter.
interface writeback_arbiter_if import cpu_pkg::*; #(
  parameter int unsigned WIDTH        = WORD_WIDTH,
  parameter int unsigned SELECT_WIDTH = 2,
  parameter int unsigned ADDR_WIDTH   = REG_ADDR_WIDTH
);

  localparam int unsigned N = 2 ** SELECT_WIDTH;

  logic [N-1:0]            in_valid;
  logic [WIDTH-1:0]        in_data [N];
  logic [ADDR_WIDTH-1:0]   in_addr [N];
  logic [N-1:0]            in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [ADDR_WIDTH-1:0]   out_addr;
  logic [SELECT_WIDTH-1:0] out_src;
  logic                    out_ready;

  modport master (
    output in_valid, in_data, in_addr, out_ready,
    input  in_ready, out_valid, out_data, out_addr, out_src
  );

  modport slave (
    input  in_valid, in_data, in_addr, out_ready,
    output in_ready, out_valid, out_data, out_addr, out_src
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational rotating-priority picker: first set request at or after ptr (mod N) wins.
module rr_picker #(
  parameter int unsigned SELECT_WIDTH = 2,
  localparam int unsigned N = 2 ** SELECT_WIDTH
) (
  input  logic [N-1:0]            req,
  input  logic [SELECT_WIDTH-1:0] ptr,
  input  logic                    enable,
  output logic [N-1:0]            grant,
  output logic [SELECT_WIDTH-1:0] grant_idx
);

  logic                    found;
  logic [SELECT_WIDTH-1:0] idx;

  // Scan from ptr upward; index arithmetic wraps naturally at SELECT_WIDTH bits.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = ptr + SELECT_WIDTH'(k);
      if (enable && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges 2**SELECT_WIDTH functional-unit results onto the single register-file write port
// through one registered slot. Round-robin by default; defining WB_ARB_FIXED_PRIO_EN selects
// fixed priority (lowest index wins) and removes the rotating pointer.
module writeback_arbiter import cpu_pkg::*; #(
  parameter int unsigned WIDTH        = WORD_WIDTH,
  parameter int unsigned SELECT_WIDTH = 2,
  parameter int unsigned ADDR_WIDTH   = REG_ADDR_WIDTH
) (
  input logic                clk,
  input logic                reset_n,
  writeback_arbiter_if.slave bus
);

  localparam int unsigned N = 2 ** SELECT_WIDTH;

  logic                    load_en;
  logic [N-1:0]            grant;
  logic [SELECT_WIDTH-1:0] grant_idx;
  logic [SELECT_WIDTH-1:0] scan_ptr;

  logic                    out_valid_q, out_valid_d;
  logic [WIDTH-1:0]        out_data_q,  out_data_d;
  logic [ADDR_WIDTH-1:0]   out_addr_q,  out_addr_d;
  logic [SELECT_WIDTH-1:0] out_src_q,   out_src_d;

`ifdef WB_ARB_FIXED_PRIO_EN
  assign scan_ptr = '0;
`else
  logic [SELECT_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  assign scan_ptr = rr_ptr_q;
`endif

  // Slot is free when empty or being drained this cycle; nothing is granted during reset.
  assign load_en = reset_n && (!out_valid_q || bus.out_ready);

  rr_picker #(
    .SELECT_WIDTH(SELECT_WIDTH)
  ) u_picker (
    .req      (bus.in_valid),
    .ptr      (scan_ptr),
    .enable   (load_en),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  assign bus.in_ready  = grant;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_src   = out_src_q;

  // Next slot contents: load on grant, drop valid on drain, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_src_d   = out_src_q;
`ifndef WB_ARB_FIXED_PRIO_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    if (|grant) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[grant_idx];
      out_addr_d  = bus.in_addr[grant_idx];
      out_src_d   = grant_idx;
`ifndef WB_ARB_FIXED_PRIO_EN
      rr_ptr_d    = grant_idx + SELECT_WIDTH'(1);
`endif
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Slot and pointer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_src_q   <= '0;
`ifndef WB_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_src_q   <= out_src_d;
`ifndef WB_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: a reference arbitration model pushes expected
// slot contents into a scoreboard at grant time; tests pop and compare once the slot loads.
module tb_writeback_arbiter;
  import cpu_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  writeback_arbiter_if bus ();

  writeback_arbiter dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [1:0] src;
    word_t      data;
    reg_addr_t  addr;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  int           vectors = 0;
  int           errors  = 0;
  logic [1:0]   m_ptr   = '0;
  logic         m_valid = 1'b0;
  logic [N-1:0] exp_rdy;
  logic [N-1:0] obs_rdy;
  bit           loaded;

  task automatic clear_srcs();
    for (int i = 0; i < N; i++) begin
      bus.in_valid[i] = 1'b0;
      bus.in_data[i]  = '0;
      bus.in_addr[i]  = '0;
    end
  endtask

  task automatic set_src(input int i, input word_t d, input reg_addr_t a);
    bus.in_valid[i] = 1'b1;
    bus.in_data[i]  = d;
    bus.in_addr[i]  = a;
  endtask

  // One clock: model the grant mid-cycle, capture in_ready, push expected entry, advance model.
  task automatic tick();
    int   g;
    logic ld;
    @(negedge clk);
    ld = reset_n && (!m_valid || bus.out_ready);
    g  = -1;
    if (ld) begin
      for (int k = 0; k < N; k++) begin
        int idx;
`ifdef WB_ARB_FIXED_PRIO_EN
        idx = k;
`else
        idx = (int'(m_ptr) + k) % N;
`endif
        if (g < 0 && bus.in_valid[idx]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    obs_rdy = bus.in_ready;
    loaded  = (g >= 0);
    if (g >= 0) sb.push_back('{src: 2'(g), data: bus.in_data[g], addr: bus.in_addr[g]});
    @(posedge clk);
    #1;
    if (!reset_n) begin
      m_valid = 1'b0;
      m_ptr   = '0;
    end else if (g >= 0) begin
      m_valid = 1'b1;
      m_ptr   = 2'(g + 1);
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic reset_cycle();
    reset_n = 1'b0;
    clear_srcs();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_src(i, word_t'(16'h0010 + i), reg_addr_t'(i));
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++;
      if (obs_rdy !== 4'b0000) begin
        errors++;
        $display("FAIL reset_in_ready[%0d] got %b want 0000", c, obs_rdy);
      end
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0 || bus.out_addr !== 4'h0 ||
          bus.out_src !== 2'd0) begin
        errors++;
        $display("FAIL reset_out[%0d] got v=%b d=%h a=%h s=%0d want v=0 d=0000 a=0 s=0", c,
                 bus.out_valid, bus.out_data, bus.out_addr, bus.out_src);
      end
    end
    reset_n = 1'b1;
    tick();
    vectors++;
    if (obs_rdy !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant got %b want 0001", obs_rdy);
    end
    if (loaded) begin
      e = sb.pop_front();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_src !== e.src || bus.out_data !== e.data ||
          bus.out_addr !== e.addr || bus.out_src !== 2'd0) begin
        errors++;
        $display("FAIL reset_first_out got v=%b s=%0d d=%h a=%h want v=1 s=0 d=%h a=%h",
                 bus.out_valid, bus.out_src, bus.out_data, bus.out_addr, e.data, e.addr);
      end
    end
  endtask

  task automatic test_round_robin();
    reset_cycle();
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_src(i, word_t'(16'h00A0 + i), reg_addr_t'(i));
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (obs_rdy !== 4'(1 << (k % N))) begin
        errors++;
        $display("FAIL sweep_in_ready[%0d] got %b want %b", k, obs_rdy, 4'(1 << (k % N)));
      end
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_src !== 2'(k % N) ||
          bus.out_data !== word_t'(16'h00A0 + k % N)) begin
        errors++;
        $display("FAIL sweep_out[%0d] got v=%b s=%0d d=%h want v=1 s=%0d d=%h", k,
                 bus.out_valid, bus.out_src, bus.out_data, k % N, 16'h00A0 + k % N);
      end
      if (loaded) begin
        e = sb.pop_front();
        vectors++;
        if (bus.out_src !== e.src || bus.out_data !== e.data || bus.out_addr !== e.addr) begin
          errors++;
          $display("FAIL sweep_sb[%0d] got s=%0d d=%h a=%h want s=%0d d=%h a=%h", k,
                   bus.out_src, bus.out_data, bus.out_addr, e.src, e.data, e.addr);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    // Pointer sits at 1 after the sweep, so a lone source 2 is picked next.
    clear_srcs();
    set_src(2, 16'hBEEF, 4'd5);
    bus.out_ready = 1'b1;
    tick();
    if (loaded) e = sb.pop_front();
    vectors++;
    if (obs_rdy !== 4'b0100 || bus.out_src !== 2'd2 || bus.out_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL bp_accept got rdy=%b s=%0d d=%h want rdy=0100 s=2 d=BEEF", obs_rdy,
               bus.out_src, bus.out_data);
    end
    clear_srcs();
    set_src(0, 16'h1111, 4'd1);
    set_src(3, 16'h3333, 4'd9);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (obs_rdy !== 4'b0000 || bus.out_valid !== 1'b1 || bus.out_data !== 16'hBEEF ||
          bus.out_addr !== 4'd5 || bus.out_src !== 2'd2) begin
        errors++;
        $display("FAIL bp_hold[%0d] got rdy=%b v=%b d=%h a=%0d s=%0d want 0000/1/BEEF/5/2", c,
                 obs_rdy, bus.out_valid, bus.out_data, bus.out_addr, bus.out_src);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    vectors++;
    if (obs_rdy !== 4'b1000) begin
      errors++;
      $display("FAIL bp_resume_rdy got %b want 1000", obs_rdy);
    end
    if (loaded) begin
      e = sb.pop_front();
      vectors++;
      if (bus.out_src !== e.src || bus.out_data !== e.data || bus.out_addr !== e.addr ||
          bus.out_data !== 16'h3333) begin
        errors++;
        $display("FAIL bp_resume_out got s=%0d d=%h a=%h want s=3 d=3333 a=9", bus.out_src,
                 bus.out_data, bus.out_addr);
      end
    end
    clear_srcs();
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h3333 || bus.out_src !== 2'd3) begin
      errors++;
      $display("FAIL bp_drain got v=%b d=%h s=%0d want v=0 d=3333 s=3", bus.out_valid,
               bus.out_data, bus.out_src);
    end
  endtask

  task automatic test_sparse_wrap();
    int        want_src [7];
    logic      want_v   [7];
    logic [3:0] pattern [7];
    pattern  = '{4'b1000, 4'b0000, 4'b0010, 4'b0000, 4'b1010, 4'b0000, 4'b0011};
    want_src = '{3, 3, 1, 1, 3, 3, 0};
    want_v   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    reset_cycle();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      clear_srcs();
      for (int i = 0; i < N; i++)
        if (pattern[k][i]) set_src(i, word_t'(16'h5000 + 16 * k + i), reg_addr_t'(k + i));
      tick();
      vectors++;
      if (bus.out_valid !== want_v[k] || bus.out_src !== 2'(want_src[k])) begin
        errors++;
        $display("FAIL sparse[%0d] got v=%b s=%0d want v=%b s=%0d", k, bus.out_valid,
                 bus.out_src, want_v[k], want_src[k]);
      end
      if (loaded) begin
        e = sb.pop_front();
        vectors++;
        if (bus.out_src !== e.src || bus.out_data !== e.data || bus.out_addr !== e.addr) begin
          errors++;
          $display("FAIL sparse_sb[%0d] got s=%0d d=%h a=%h want s=%0d d=%h a=%h", k,
                   bus.out_src, bus.out_data, bus.out_addr, e.src, e.data, e.addr);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    reset_cycle();
    bus.out_ready = 1'b1;
    set_src(1, 16'h0101, 4'd1);
    tick();
    if (loaded) e = sb.pop_front();
    set_src(2, 16'h0202, 4'd2);
    bus.out_ready = 1'b0;
    tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd1 || obs_rdy !== 4'b0000) begin
      errors++;
      $display("FAIL mid_hold got v=%b s=%0d rdy=%b want v=1 s=1 rdy=0000", bus.out_valid,
               bus.out_src, obs_rdy);
    end
    reset_n = 1'b0;
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_src !== 2'd0 || obs_rdy !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset got v=%b s=%0d rdy=%b want v=0 s=0 rdy=0000", bus.out_valid,
               bus.out_src, obs_rdy);
    end
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    vectors++;
    if (obs_rdy !== 4'b0010) begin
      errors++;
      $display("FAIL mid_regrant_rdy got %b want 0010", obs_rdy);
    end
    if (loaded) begin
      e = sb.pop_front();
      vectors++;
      if (bus.out_src !== e.src || bus.out_data !== e.data || bus.out_data !== 16'h0101) begin
        errors++;
        $display("FAIL mid_regrant_out got s=%0d d=%h want s=1 d=0101", bus.out_src,
                 bus.out_data);
      end
    end
  endtask

  task automatic test_fixed_prio();
    reset_cycle();
    bus.out_ready = 1'b1;
    set_src(0, 16'hF000, 4'd0);
    set_src(3, 16'hF333, 4'd3);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) bus.in_valid[0] = 1'b0;
      tick();
      vectors++;
      if (bus.out_src !== (k == 4 ? 2'd3 : 2'd0) || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL fixed[%0d] got v=%b s=%0d want v=1 s=%0d", k, bus.out_valid,
                 bus.out_src, (k == 4) ? 3 : 0);
      end
      if (loaded) begin
        e = sb.pop_front();
        vectors++;
        if (bus.out_src !== e.src || bus.out_data !== e.data || bus.out_addr !== e.addr) begin
          errors++;
          $display("FAIL fixed_sb[%0d] got s=%0d d=%h want s=%0d d=%h", k, bus.out_src,
                   bus.out_data, e.src, e.data);
        end
      end
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.out_ready = 1'b0;
    clear_srcs();
    test_reset();
`ifdef WB_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_round_robin();
    test_backpressure();
    test_sparse_wrap();
    test_reset_mid();
`endif
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
